// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-source mux select arbiter.
// The state encoding is fixed so that grant bits map directly onto state bits.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_e;

   localparam int HOLD_MAX_DEF = 4;
   localparam int CNT_W_DEF    = 3;

endpackage

// File: rtl/arb_hold_counter.sv
// Clearable hold counter that saturates at LIMIT and flags it.
// Clear has priority over enable.
module arb_hold_counter #(
   parameter int CNT_W = 3,
   parameter int LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             at_limit
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign at_limit = (cnt_q == LIM);
   assign cnt      = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !at_limit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter with bounded hold for the 2:1 select mux.
// Define MUX_ARB_LOCK_EN to add the lock port that suppresses forced rotation.
module mux_select_arbiter
   import mux_arb_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic s,
   output logic grant0,
   output logic grant1,
   output logic busy
`ifdef MUX_ARB_LOCK_EN
   ,
   input  logic lock
`endif
);

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic             last_q;
   logic             last_d;
   logic             s_q;
   logic             s_d;
   logic             cnt_clr;
   logic             cnt_en;
   logic             at_limit;
   logic             lock_w;
   logic [CNT_W-1:0] hold_cnt;

`ifdef MUX_ARB_LOCK_EN
   assign lock_w = lock;
`else
   assign lock_w = 1'b0;
`endif

   arb_hold_counter #(
      .CNT_W (CNT_W),
      .LIMIT (HOLD_MAX - 1)
   ) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .cnt      (hold_cnt),
      .at_limit (at_limit)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      s_d     = s_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (req0 && req1) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (req0) begin
               state_d = GNT0;
            end else if (req1) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (!req0) begin
               state_d = req1 ? GNT1 : IDLE;
               last_d  = 1'b0;
               cnt_clr = 1'b1;
            end else if (at_limit && req1 && !lock_w) begin
               state_d = GNT1;
               last_d  = 1'b0;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         GNT1: begin
            if (!req1) begin
               state_d = req0 ? GNT0 : IDLE;
               last_d  = 1'b1;
               cnt_clr = 1'b1;
            end else if (at_limit && req0 && !lock_w) begin
               state_d = GNT0;
               last_d  = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_clr = 1'b1;
         end
      endcase
      // select follows the new owner; it parks on its last value when idle
      if (state_d == GNT0) begin
         s_d = 1'b0;
      end else if (state_d == GNT1) begin
         s_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         s_q     <= s_d;
      end
   end

   assign grant0 = (state_q == GNT0);
   assign grant1 = (state_q == GNT1);
   assign busy   = grant0 | grant1;
   assign s      = s_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Randomized bench for mux_select_arbiter with a cycle-level ownership model.
// Define MUX_ARB_LOCK_EN to also exercise the lock port.
module tb_mux_select_arbiter;

   localparam int HOLD_MAX = 4;

   logic clk;
   logic rst_n;
   logic req0;
   logic req1;
   logic lock_in;
   logic s;
   logic grant0;
   logic grant1;
   logic busy;

   int n_cmp;
   int n_bad;

   // model: who owns the path, how many cycles it has owned it, who went last
   int   m_owner;
   int   m_held;
   bit   m_last;
   bit   m_s;

   mux_select_arbiter #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (3)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0),
      .req1   (req1),
      .s      (s),
      .grant0 (grant0),
      .grant1 (grant1),
      .busy   (busy)
`ifdef MUX_ARB_LOCK_EN
      ,
      .lock   (lock_in)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 1'b1;
      m_s     = 1'b0;
   endfunction

   function automatic void model_step(input bit r0, input bit r1,
                                      input bit lk);
      bit mine;
      bit other;
      if (m_owner < 0) begin
         if (r0 && r1)  m_owner = m_last ? 0 : 1;
         else if (r0)   m_owner = 0;
         else if (r1)   m_owner = 1;
         m_held = 1;
      end else begin
         mine  = (m_owner == 0) ? r0 : r1;
         other = (m_owner == 0) ? r1 : r0;
         if (!mine) begin
            m_last  = (m_owner == 1);
            m_owner = other ? 1 - m_owner : -1;
            m_held  = 1;
         end else if (other && m_held >= HOLD_MAX && !lk) begin
            m_last  = (m_owner == 1);
            m_owner = 1 - m_owner;
            m_held  = 1;
         end else begin
            m_held++;
         end
      end
      if (m_owner >= 0) m_s = (m_owner == 1);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step(req0, req1, lock_in);
      #1;
      chk("cycle", {4'b0, s, grant0, grant1, busy},
          {4'b0, m_s, m_owner == 0, m_owner == 1, m_owner >= 0});
      chk("exclusive", {7'b0, grant0 & grant1}, 8'h00);
   end

   function automatic logic [7:0] outs();
      return {4'b0, s, grant0, grant1, busy};
   endfunction

   initial begin
      int waited;
      n_cmp   = 0;
      n_bad   = 0;
      model_reset();
      rst_n   = 1'b0;
      req0    = 1'b0;
      req1    = 1'b0;
      lock_in = 1'b0;

      // reset state, then release with no requests
      repeat (2) @(negedge clk);
      chk("reset_outs", outs(), 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_release", outs(), 8'h00);

      // single requester
      req0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("single_g0", outs(), 8'b0000_0101);
      end
      req0 = 1'b0;
      @(negedge clk);
      chk("single_idle", outs(), 8'h00);

      // tie after reset: four cycles of source 0, then straight to source 1
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      for (int i = 0; i < HOLD_MAX; i++) begin
         @(negedge clk);
         chk("tie_g0", outs(), 8'b0000_0101);
      end
      @(negedge clk);
      chk("tie_g1", outs(), 8'b0000_1011);

      // async reset between edges while source 1 owns the path
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_clear", outs(), 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_g0", outs(), 8'b0000_0101);

      // starvation bound for source 0 behind a streaming source 1
      req0 = 1'b0;
      req1 = 1'b1;
      repeat (3) @(negedge clk);
      req0   = 1'b1;
      waited = HOLD_MAX + 2;
      for (int k = 1; k <= HOLD_MAX + 1; k++) begin
         @(negedge clk);
         if (grant0) begin
            waited = k;
            break;
         end
      end
      chk("starve_bound", {7'b0, waited <= HOLD_MAX + 1}, 8'h01);

`ifdef MUX_ARB_LOCK_EN
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      req0    = 1'b1;
      req1    = 1'b1;
      lock_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("lock_hold_g0", outs(), 8'b0000_0101);
      end
      lock_in = 1'b0;
      @(negedge clk);
      chk("lock_release_g1", outs(), 8'b0000_1011);
`endif

      // randomized traffic, occasionally bursty
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) != 0) req0 = 1'($urandom);
         if ($urandom_range(0, 3) != 0) req1 = 1'($urandom);
`ifdef MUX_ARB_LOCK_EN
         lock_in = ($urandom_range(0, 9) == 0);
`endif
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
